// File: rtl/board_tilemap.sv
// board_tilemap: 8x8 chessboard tile map with an Avalon-MM register file,
// a fill sequencer and a 2-stage pixel-to-sprite lookup pipeline.
module board_tilemap #(
    parameter int TILE = 60,
    parameter int X0 = 0,
    parameter int Y0 = 0,
    parameter int CODE_W = 4,
    parameter logic [CODE_W-1:0] EMPTY_CODE = CODE_W'(4'hc),
    parameter int PIX_W = 12
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic              AVL_CS,
    input  logic [6:0]        AVL_ADDR,
    input  logic [7:0]        AVL_WRITEDATA,
    output logic [7:0]        AVL_READDATA,
    output logic [PIX_W-1:0]  pixel_addr,
    output logic [CODE_W-1:0] img_addr,
    output logic              board_on,
    output logic              background_index,
    output logic [1:0]        hilite
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;
    localparam logic [9:0] X0_L = 10'(X0);
    localparam logic [9:0] Y0_L = 10'(Y0);
    localparam logic [9:0] T_L = 10'(TILE);
    localparam logic [9:0] BW_L = 10'(8 * TILE);
    localparam logic [11:0] T12 = 12'(TILE);

    function automatic logic [CODE_W-1:0] layout(input logic [5:0] i);
        logic [3:0] back;
        case (i[2:0])
            3'd0, 3'd7: back = 4'h6;
            3'd1, 3'd6: back = 4'h4;
            3'd2, 3'd5: back = 4'h2;
            3'd3:       back = 4'h8;
            default:    back = 4'ha;
        endcase
        case (i[5:3])
            3'd0:    layout = CODE_W'(back);
            3'd1:    layout = '0;
            3'd6:    layout = CODE_W'(4'h1);
            3'd7:    layout = CODE_W'(back + 4'h1);
            default: layout = EMPTY_CODE;
        endcase
    endfunction

    logic [CODE_W-1:0] cell_q [64];
    logic [CODE_W-1:0] cell_d [64];
    logic [0:0] st_q, st_d;
    logic [5:0] idx_q, idx_d;
    logic init_q, init_d;
    logic [6:0] sel_q, sel_d;
    logic [6:0] cur_q, cur_d;
    logic [7:0] rdata_q, rdata_d;

    logic on1_q, on1_d;
    logic [2:0] bx1_q, bx1_d, by1_q, by1_d;
    logic [5:0] ox1_q, ox1_d, oy1_q, oy1_d;
    logic on2_q, on2_d;
    logic [PIX_W-1:0] pa_q, pa_d;
    logic [CODE_W-1:0] img_q, img_d;
    logic bg_q, bg_d;
    logic [1:0] hl_q, hl_d;

    logic wr, rd, busy;
    logic [10:0] dx, dy;
    logic [5:0] sq;
    logic [11:0] pa_full;

    assign wr = AVL_CS & AVL_WRITE;
    assign rd = AVL_CS & AVL_READ;
    assign busy = (st_q == ST_FILL);

    always_comb begin
        cell_d = cell_q;
        st_d = st_q;
        idx_d = idx_q;
        init_d = init_q;
        sel_d = sel_q;
        cur_d = cur_q;
        rdata_d = rdata_q;
        // Reads see the array before this cycle's writes land.
        if (rd) begin
            unique case (1'b1)
                !AVL_ADDR[6]:       rdata_d = 8'(cell_q[AVL_ADDR[5:0]]);
                AVL_ADDR == 7'd65: rdata_d = {7'd0, busy};
                AVL_ADDR == 7'd66: rdata_d = {1'b0, sel_q};
                AVL_ADDR == 7'd67: rdata_d = {1'b0, cur_q};
                default:           rdata_d = 8'd0;
            endcase
        end
        if (wr) begin
            unique case (1'b1)
                !AVL_ADDR[6]: begin
                    if (!busy) cell_d[AVL_ADDR[5:0]] = CODE_W'(AVL_WRITEDATA);
                end
                AVL_ADDR == 7'd64: begin
                    if (!busy && (AVL_WRITEDATA[1:0] != 2'b00)) begin
                        st_d = ST_FILL;
                        idx_d = 6'd0;
                        init_d = AVL_WRITEDATA[0];
                    end
                end
                AVL_ADDR == 7'd66: sel_d = AVL_WRITEDATA[6:0];
                AVL_ADDR == 7'd67: cur_d = AVL_WRITEDATA[6:0];
                default: ;
            endcase
        end
        if (busy) begin
            cell_d[idx_q] = init_q ? layout(idx_q) : EMPTY_CODE;
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'd63) st_d = ST_IDLE;
        end
    end

    always_comb begin
        // 11-bit difference: bit 10 flags a pixel left of / above the origin.
        dx = {1'b0, DrawX} - {1'b0, X0_L};
        dy = {1'b0, DrawY} - {1'b0, Y0_L};
        on1_d = !dx[10] && (dx[9:0] < BW_L) && !dy[10] && (dy[9:0] < BW_L);
        bx1_d = on1_d ? 3'(dx[9:0] / T_L) : 3'd0;
        by1_d = on1_d ? 3'(dy[9:0] / T_L) : 3'd0;
        ox1_d = on1_d ? 6'(dx[9:0] % T_L) : 6'd0;
        oy1_d = on1_d ? 6'(dy[9:0] % T_L) : 6'd0;
        sq = {by1_q, bx1_q};
        pa_full = 12'(oy1_q) * T12 + 12'(ox1_q);
        on2_d = on1_q;
        pa_d = on1_q ? PIX_W'(pa_full) : '0;
        img_d = on1_q ? cell_q[sq] : EMPTY_CODE;
        bg_d = on1_q & (bx1_q[0] ^ by1_q[0]);
        hl_d[0] = on1_q & sel_q[6] & (sel_q[5:0] == sq);
        hl_d[1] = on1_q & cur_q[6] & (cur_q[5:0] == sq);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 64; i++) cell_q[i] <= layout(6'(i));
            st_q <= ST_IDLE;
            idx_q <= 6'd0;
            init_q <= 1'b0;
            sel_q <= 7'd0;
            cur_q <= 7'd0;
            rdata_q <= 8'd0;
            on1_q <= 1'b0;
            bx1_q <= 3'd0;
            by1_q <= 3'd0;
            ox1_q <= 6'd0;
            oy1_q <= 6'd0;
            on2_q <= 1'b0;
            pa_q <= '0;
            img_q <= EMPTY_CODE;
            bg_q <= 1'b0;
            hl_q <= 2'b00;
        end else begin
            cell_q <= cell_d;
            st_q <= st_d;
            idx_q <= idx_d;
            init_q <= init_d;
            sel_q <= sel_d;
            cur_q <= cur_d;
            rdata_q <= rdata_d;
            on1_q <= on1_d;
            bx1_q <= bx1_d;
            by1_q <= by1_d;
            ox1_q <= ox1_d;
            oy1_q <= oy1_d;
            on2_q <= on2_d;
            pa_q <= pa_d;
            img_q <= img_d;
            bg_q <= bg_d;
            hl_q <= hl_d;
        end
    end

    assign AVL_READDATA = rdata_q;
    assign pixel_addr = pa_q;
    assign img_addr = img_q;
    assign board_on = on2_q;
    assign background_index = bg_q;
    assign hilite = hl_q;

endmodule

// File: tb/tb_board_tilemap.sv
// Scoreboard bench for board_tilemap: two instances (origin 0 and X0=80),
// expected responses queued at issue and checked by a separate monitor.
module tb_board_tilemap;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic [9:0] DrawX, DrawY;
    logic AVL_READ, AVL_WRITE, AVL_CS;
    logic [6:0] AVL_ADDR;
    logic [7:0] AVL_WRITEDATA;

    logic [7:0] rdata, rdata_o;
    logic [11:0] pa, pa_o;
    logic [3:0] img, img_o;
    logic on, on_o, bg, bg_o;
    logic [1:0] hl, hl_o;

    always #5 CLK = ~CLK;

    board_tilemap dut (
        .CLK(CLK), .RESET_N(RESET_N), .DrawX(DrawX), .DrawY(DrawY),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(rdata), .pixel_addr(pa), .img_addr(img),
        .board_on(on), .background_index(bg), .hilite(hl)
    );

    board_tilemap #(.X0(80)) dut_o (
        .CLK(CLK), .RESET_N(RESET_N), .DrawX(DrawX), .DrawY(DrawY),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(rdata_o), .pixel_addr(pa_o), .img_addr(img_o),
        .board_on(on_o), .background_index(bg_o), .hilite(hl_o)
    );

    typedef struct {
        int v;
        string nm;
    } rd_exp_t;

    typedef struct {
        int o;
        int on;
        int pa;
        int img;
        int bg;
        int hl;
        string nm;
    } px_exp_t;

    rd_exp_t rdq[$];
    px_exp_t pxq[$];
    rd_exp_t re;
    px_exp_t pe;
    int passed = 0;
    int total = 0;
    logic rd_d;
    logic [1:0] pv;
    logic px_issue = 1'b0;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_d <= 1'b0;
            pv <= 2'b00;
        end else begin
            rd_d <= AVL_CS & AVL_READ;
            pv <= {pv[0], px_issue};
        end
    end

    always @(negedge CLK) begin
        if (rd_d) begin
            if (rdq.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                re = rdq.pop_front();
                chk(re.nm, int'(rdata), re.v);
            end
        end
        if (pv[1]) begin
            if (pxq.size() == 0) begin
                chk("px_unexpected", 1, 0);
            end else begin
                pe = pxq.pop_front();
                if (pe.o == 0) begin
                    chk({pe.nm, ".on"}, int'(on), pe.on);
                    chk({pe.nm, ".pa"}, int'(pa), pe.pa);
                    chk({pe.nm, ".img"}, int'(img), pe.img);
                    chk({pe.nm, ".bg"}, int'(bg), pe.bg);
                    chk({pe.nm, ".hl"}, int'(hl), pe.hl);
                end else begin
                    chk({pe.nm, ".on"}, int'(on_o), pe.on);
                    chk({pe.nm, ".pa"}, int'(pa_o), pe.pa);
                    chk({pe.nm, ".img"}, int'(img_o), pe.img);
                    chk({pe.nm, ".bg"}, int'(bg_o), pe.bg);
                    chk({pe.nm, ".hl"}, int'(hl_o), pe.hl);
                end
            end
        end
    end

    task automatic bus(input logic w, input logic r,
                       input int a, input int d);
        AVL_CS = w | r;
        AVL_WRITE = w;
        AVL_READ = r;
        AVL_ADDR = 7'(a);
        AVL_WRITEDATA = 8'(d);
        @(negedge CLK);
        AVL_CS = 1'b0;
        AVL_WRITE = 1'b0;
        AVL_READ = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input int a, input int exp, input string nm);
        rdq.push_back('{v: exp, nm: nm});
        bus(1'b0, 1'b1, a, 0);
    endtask

    task automatic rdwr(input int a, input int d, input int exp,
                        input string nm);
        rdq.push_back('{v: exp, nm: nm});
        bus(1'b1, 1'b1, a, d);
    endtask

    task automatic px(input int o, input int x, input int y, input int b_on,
                      input int p, input int im, input int b, input int h,
                      input string nm);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pxq.push_back('{o: o, on: b_on, pa: p, img: im, bg: b, hl: h, nm: nm});
        px_issue = 1'b1;
        @(negedge CLK);
        px_issue = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (rdq.size() + pxq.size()) > 0; i++)
            @(negedge CLK);
        if ((rdq.size() + pxq.size()) > 0)
            chk("drain_timeout", rdq.size() + pxq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        AVL_CS = 1'b0;
        AVL_READ = 1'b0;
        AVL_WRITE = 1'b0;
        AVL_ADDR = 7'd0;
        AVL_WRITEDATA = 8'd0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        repeat (2) @(negedge CLK);
        chk("rst_readdata", int'(rdata), 0);
        chk("rst_on", int'(on), 0);
        chk("rst_pa", int'(pa), 0);
        chk("rst_img", int'(img), 'hc);
        chk("rst_bg", int'(bg), 0);
        chk("rst_hl", int'(hl), 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        rd(0, 'h6, "cell0");
        rd(7, 'h6, "cell7");
        rd(20, 'hc, "cell20");
        rd(59, 'h9, "cell59");
        rd(60, 'hb, "cell60");
        rd(65, 0, "status_idle");
        wr(20, 5);
        rd(20, 5, "cell20_wr");
        rdwr(21, 3, 'hc, "same_cycle_old");
        rd(21, 3, "same_cycle_new");
        rd(64, 0, "ctrl_reads0");
        wr(100, 'h55);
        rd(100, 0, "unmapped");
        wr(66, 'h2a);
        rd(66, 'h2a, "sel_rb");
        drain();

        wr(64, 2);
        for (int i = 0; i < 64; i++) rd(65, 1, "clear_busy");
        rd(65, 0, "clear_done");
        rd(0, 'hc, "clear_cell0");
        rd(20, 'hc, "clear_cell20");
        drain();

        wr(64, 1);
        wr(3, 0);
        wr(64, 2);
        repeat (70) @(negedge CLK);
        rd(3, 'h8, "drop_cell3");
        rd(20, 'hc, "init_cell20");
        rd(63, 'h7, "init_cell63");
        drain();

        px(0, 61, 125, 1, 301, 'hc, 1, 0, "px_main");
        px(0, 480, 125, 0, 0, 'hc, 0, 0, "px_right");
        px(0, 479, 479, 1, 3599, 'h7, 0, 0, "px_corner");
        px(0, 100, 480, 0, 0, 'hc, 0, 0, "px_bottom");
        px(0, 60, 0, 1, 0, 'h4, 1, 0, "px_tile1");
        px(1, 79, 0, 0, 0, 'hc, 0, 0, "org_left");
        px(1, 80, 0, 1, 0, 'h6, 0, 0, "org_in");
        px(1, 559, 0, 1, 59, 'h6, 1, 0, "org_right");
        drain();

        wr(66, 'h51);
        px(0, 70, 130, 1, 610, 'hc, 1, 1, "hl_sel");
        drain();
        wr(67, 'h51);
        rd(67, 'h51, "cur_rb");
        px(0, 70, 130, 1, 610, 'hc, 1, 3, "hl_both");
        px(0, 10, 130, 1, 610, 'hc, 0, 0, "hl_other");
        drain();

        wr(64, 2);
        repeat (10) @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        rd(65, 0, "abort_busy");
        rd(0, 'h6, "abort_cell0");
        rd(12, 0, "abort_cell12");
        rd(20, 'hc, "abort_cell20");
        rd(52, 1, "abort_cell52");
        rd(60, 'hb, "abort_cell60");
        rd(66, 0, "abort_sel");
        px(0, 70, 130, 1, 610, 'hc, 1, 0, "abort_px");
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
